cmos_pattern_src: RTL and testbench

//  Parametrised DVP camera-source emulator: drives cmos_vsync/cmos_href/cmos_data like the OV5640 port,

---
 rtl/cmos_pattern_src_pkg.sv | 42 ++++
 rtl/cmos_pattern_src_pix.sv | 52 +++++
 rtl/cmos_pattern_src.sv | 208 ++++++++++++++++++++
 tb/tb_cmos_pattern_src.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pattern_src_pkg.sv
// Shared definitions for the DVP camera-source emulator:
// FSM states, pattern mode codes, colour-bar table and LFSR step.
package cmos_pattern_src_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_LINE   = 3'd3,
      ST_HBLANK = 3'd4,
      ST_VFRONT = 3'd5
   } state_t;

   localparam logic [2:0] MODE_BARS  = 3'd0;
   localparam logic [2:0] MODE_RAMP  = 3'd1;
   localparam logic [2:0] MODE_CHECK = 3'd2;
   localparam logic [2:0] MODE_NOISE = 3'd3;
   localparam logic [2:0] MODE_SOLID = 3'd4;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

endpackage

// File: rtl/cmos_pattern_src_pix.sv
// Pattern generator: registers one RGB565 pixel per ld_i strobe.
// Ports: clk_pixel/rst, seed_i (frame start), ld_i, mode_i, fill_i, h_i, v_i, bar_i -> pix_o.
module cmos_pattern_pix
   import cmos_pattern_src_pkg::*;
#(
   parameter int CHECK_LOG2 = 4
) (
   input  logic        clk_pixel,
   input  logic        rst,
   input  logic        seed_i,
   input  logic        ld_i,
   input  logic [2:0]  mode_i,
   input  logic [15:0] fill_i,
   input  logic [15:0] h_i,
   input  logic [15:0] v_i,
   input  logic [2:0]  bar_i,
   output logic [15:0] pix_o
);

   logic [15:0] lfsr_q;
   logic [15:0] pat;
   logic        unused_ok;

   assign unused_ok = ^{h_i, v_i};

   always_comb begin
      pat = 16'h0000;
      case (mode_i)
         MODE_BARS:  pat = bar_color(bar_i);
         MODE_RAMP:  pat = {h_i[7:3], h_i[7:2], h_i[7:3]};
         MODE_CHECK: pat = (h_i[CHECK_LOG2] ^ v_i[CHECK_LOG2]) ?
                           16'h0000 : 16'hFFFF;
         MODE_NOISE: pat = lfsr_q;
         MODE_SOLID: pat = fill_i;
         default:    pat = 16'h0000;
      endcase
   end

   // LFSR holds the value of the next pixel to be loaded
   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         pix_o  <= 16'h0000;
      end else if (seed_i) begin
         lfsr_q <= LFSR_SEED;
      end else if (ld_i) begin
         pix_o  <= pat;
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

endmodule

// File: rtl/cmos_pattern_src.sv
// DVP (OV5640-style) camera source emulator with test patterns.
// Ports: clk_pixel/rst, enable_i, mode_i, fill_i -> cmos_vsync/href/data, frame_start_o, frame_cnt_o, busy_o.
module cmos_pattern_src
   import cmos_pattern_src_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PIX_FMT    = 0,
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int H_BLANK    = 256,
   parameter int VS_WIDTH   = 8,
   parameter int V_BACK     = 64,
   parameter int V_FRONT    = 64,
   parameter int CHECK_LOG2 = 4,
   parameter int FCNT_W     = 16
) (
   input  logic              clk_pixel,
   input  logic              rst,
   input  logic              enable_i,
   input  logic [2:0]        mode_i,
   input  logic [15:0]       fill_i,
   output logic              cmos_vsync,
   output logic              cmos_href,
   output logic [DATA_W-1:0] cmos_data,
   output logic              frame_start_o,
   output logic [FCNT_W-1:0] frame_cnt_o,
   output logic              busy_o
);

   localparam int BPP      = (PIX_FMT == 1) ? 1 : 2;
   localparam int LINE_LEN = H_ACTIVE * BPP;
   localparam int BAR_W    = H_ACTIVE / 8;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] line_q;
   logic [2:0]  mode_q;
   logic [15:0] fill_q;
   logic [15:0] h_c;
   logic [15:0] v_c;
   logic [15:0] bar_sub;
   logic [2:0]  bar_c;
   logic [7:0]  lo_q;
   logic [15:0] pix;
   logic [7:0]  hi_byte;
   logic        last;
   logic        last_line;
   logic        go;
   logic        beat0_nxt;
   logic        ld;

   always_comb begin
      last = 1'b0;
      case (state)
         ST_VSYNC:  last = (cnt == 32'(VS_WIDTH - 1));
         ST_VBACK:  last = (cnt == 32'(V_BACK - 1));
         ST_LINE:   last = (cnt == 32'(LINE_LEN - 1));
         ST_HBLANK: last = (cnt == 32'(H_BLANK - 1));
         ST_VFRONT: last = (cnt == 32'(V_FRONT - 1));
         default:   last = 1'b0;
      endcase
   end

   assign last_line = (line_q == 32'(V_ACTIVE - 1));
   assign go = enable_i &&
               (state == ST_IDLE || (state == ST_VFRONT && last));

   // beat0_nxt: the next edge emits the first beat of a pixel
   always_comb begin
      beat0_nxt = 1'b0;
      case (state)
         ST_VBACK:  beat0_nxt = last;
         ST_HBLANK: beat0_nxt = last && !last_line;
         ST_LINE:   beat0_nxt = !last && (BPP == 1 || cnt[0]);
         default:   beat0_nxt = 1'b0;
      endcase
   end

   // first pixel is pre-loaded at the end of vsync; every beat0
   // then consumes the held pixel and fetches the next one
   assign ld = (state == ST_VSYNC && last) || beat0_nxt;

   assign hi_byte = (PIX_FMT == 1) ? {pix[15:11], pix[15:13]}
                                   : pix[15:8];

   cmos_pattern_pix #(
      .CHECK_LOG2 (CHECK_LOG2)
   ) u_pix (
      .clk_pixel (clk_pixel),
      .rst       (rst),
      .seed_i    (go),
      .ld_i      (ld),
      .mode_i    (mode_q),
      .fill_i    (fill_q),
      .h_i       (h_c),
      .v_i       (v_c),
      .bar_i     (bar_c),
      .pix_o     (pix)
   );

   // raster coordinates of the next pixel to fetch
   always_ff @(posedge clk_pixel) begin
      if (rst || go) begin
         h_c     <= '0;
         v_c     <= '0;
         bar_c   <= '0;
         bar_sub <= '0;
      end else if (ld) begin
         if (h_c == 16'(H_ACTIVE - 1)) begin
            h_c     <= '0;
            bar_c   <= '0;
            bar_sub <= '0;
            v_c     <= (v_c == 16'(V_ACTIVE - 1)) ? '0 : v_c + 16'd1;
         end else begin
            h_c <= h_c + 16'd1;
            if (bar_sub == 16'(BAR_W - 1)) begin
               bar_sub <= '0;
               bar_c   <= bar_c + 3'd1;
            end else begin
               bar_sub <= bar_sub + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         line_q        <= '0;
         mode_q        <= '0;
         fill_q        <= '0;
         lo_q          <= '0;
         cmos_vsync    <= 1'b0;
         cmos_href     <= 1'b0;
         cmos_data     <= '0;
         frame_start_o <= 1'b0;
         frame_cnt_o   <= '0;
         busy_o        <= 1'b0;
      end else begin
         frame_start_o <= 1'b0;
         if (beat0_nxt) begin
            cmos_data <= DATA_W'(hi_byte);
            lo_q      <= pix[7:0];
         end
         if (go) begin
            state         <= ST_VSYNC;
            cnt           <= '0;
            cmos_vsync    <= 1'b1;
            frame_start_o <= 1'b1;
            frame_cnt_o   <= frame_cnt_o + FCNT_W'(1);
            busy_o        <= 1'b1;
            mode_q        <= mode_i;
            fill_q        <= fill_i;
         end else begin
            case (state)
               ST_VSYNC: begin
                  if (last) begin
                     state      <= ST_VBACK;
                     cnt        <= '0;
                     cmos_vsync <= 1'b0;
                  end else cnt <= cnt + 32'd1;
               end
               ST_VBACK: begin
                  if (last) begin
                     state     <= ST_LINE;
                     cnt       <= '0;
                     line_q    <= '0;
                     cmos_href <= 1'b1;
                  end else cnt <= cnt + 32'd1;
               end
               ST_LINE: begin
                  if (last) begin
                     state     <= ST_HBLANK;
                     cnt       <= '0;
                     cmos_href <= 1'b0;
                     cmos_data <= '0;
                  end else begin
                     cnt <= cnt + 32'd1;
                     if (!beat0_nxt) cmos_data <= DATA_W'(lo_q);
                  end
               end
               ST_HBLANK: begin
                  if (last) begin
                     cnt <= '0;
                     if (last_line) begin
                        state <= ST_VFRONT;
                     end else begin
                        state     <= ST_LINE;
                        line_q    <= line_q + 32'd1;
                        cmos_href <= 1'b1;
                     end
                  end else cnt <= cnt + 32'd1;
               end
               ST_VFRONT: begin
                  if (last) begin
                     state  <= ST_IDLE;
                     cnt    <= '0;
                     busy_o <= 1'b0;
                  end else cnt <= cnt + 32'd1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmos_pattern_src.sv
// Bench for cmos_pattern_src: small RGB565 config, frame-position reference model.
// Ports: none (drives clk/rst/enable/mode/fill, checks every output cycle by cycle).
module tb_cmos_pattern_src;

   localparam int H   = 16;
   localparam int V   = 4;
   localparam int HB  = 4;
   localparam int VS  = 2;
   localparam int VB  = 3;
   localparam int VF  = 2;
   localparam int CL  = 2;
   localparam int FW  = 3;
   localparam int BPP = 2;
   localparam int L   = H * BPP;
   localparam int LT  = L + HB;
   localparam int FRAME = VS + VB + V * LT + VF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable_i = 1'b0;
   logic [2:0]    mode_i = 3'd0;
   logic [15:0]   fill_i = 16'h0000;
   logic          cmos_vsync;
   logic          cmos_href;
   logic [7:0]    cmos_data;
   logic          frame_start_o;
   logic [FW-1:0] frame_cnt_o;
   logic          busy_o;

   int checks = 0;
   int failures = 0;
   int href_cnt;
   logic [15:0] noise [H*V];
   logic [7:0]  line0 [L];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   always #5 clk = ~clk;

   cmos_pattern_src #(
      .DATA_W     (8),
      .PIX_FMT    (0),
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .H_BLANK    (HB),
      .VS_WIDTH   (VS),
      .V_BACK     (VB),
      .V_FRONT    (VF),
      .CHECK_LOG2 (CL),
      .FCNT_W     (FW)
   ) dut (
      .clk_pixel     (clk),
      .rst           (rst),
      .enable_i      (enable_i),
      .mode_i        (mode_i),
      .fill_i        (fill_i),
      .cmos_vsync    (cmos_vsync),
      .cmos_href     (cmos_href),
      .cmos_data     (cmos_data),
      .frame_start_o (frame_start_o),
      .frame_cnt_o   (frame_cnt_o),
      .busy_o        (busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ref_pix(input int mode, input logic [15:0] fill,
                                           input int h, input int v);
      int g;
      case (mode)
         0: return bars[h / (H / 8)];
         1: begin
            g = h % 256;
            return 16'(((g >> 3) << 11) | ((g >> 2) << 5) | (g >> 3));
         end
         2: return ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 16'h0000 : 16'hFFFF;
         3: return noise[v * H + h];
         4: return fill;
         default: return 16'h0000;
      endcase
   endfunction

   // checks one full frame starting at its first vsync cycle
   task automatic run_frame(input int emode, input logic [15:0] efill,
                            input int fno, input int chg_p, input int nmode,
                            input logic [15:0] nfill, input int drop_p);
      logic ev, eh, efs;
      logic [7:0] ed;
      logic [15:0] pv;
      logic [FW-1:0] ecnt;
      int q, ln, r, px;
      ecnt = FW'(fno % (1 << FW));
      href_cnt = 0;
      for (int p = 0; p < FRAME; p++) begin
         if (p == chg_p) begin
            mode_i = 3'(nmode);
            fill_i = nfill;
         end
         if (p == drop_p) enable_i = 1'b0;
         ev = (p < VS);
         eh = 1'b0;
         ed = 8'h00;
         efs = (p == 0);
         q = p - VS - VB;
         if (q >= 0 && q < V * LT) begin
            ln = q / LT;
            r = q % LT;
            if (r < L) begin
               eh = 1'b1;
               px = r / BPP;
               pv = ref_pix(emode, efill, px, ln);
               ed = (r % 2 == 0) ? pv[15:8] : pv[7:0];
               if (ln == 0) line0[r] = cmos_data;
            end
         end
         if (cmos_href) href_cnt++;
         checks++;
         if ({cmos_vsync, cmos_href, cmos_data, frame_start_o, busy_o}
               !== {ev, eh, ed, efs, 1'b1} || frame_cnt_o !== ecnt) begin
            failures++;
            $display("FAIL frame%0d p=%0d got vs=%b hr=%b d=%h fs=%b bz=%b fc=%0d want vs=%b hr=%b d=%h fs=%b bz=1 fc=%0d",
                     fno, p, cmos_vsync, cmos_href, cmos_data, frame_start_o,
                     busy_o, frame_cnt_o, ev, eh, ed, efs, ecnt);
         end
         tick();
      end
   endtask

   task automatic check_idle(input string nm, input int n, input int fc);
      for (int i = 0; i < n; i++) begin
         checks++;
         if ({cmos_vsync, cmos_href, cmos_data, frame_start_o, busy_o} !== 12'h000
               || frame_cnt_o !== FW'(fc)) begin
            failures++;
            $display("FAIL %s cyc=%0d got vs=%b hr=%b d=%h fs=%b bz=%b fc=%0d want all 0 fc=%0d",
                     nm, i, cmos_vsync, cmos_href, cmos_data, frame_start_o,
                     busy_o, frame_cnt_o, fc);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable_i = 1'b1;
      mode_i = 3'd0;
      tick();
      check_idle("reset", 10, 0);
      rst = 1'b0;
      tick();
      checks++;
      if ({cmos_vsync, cmos_href, frame_start_o, busy_o, frame_cnt_o}
            !== {4'b1011, FW'(1)}) begin
         failures++;
         $display("FAIL first_vsync got vs=%b hr=%b fs=%b bz=%b fc=%0d want 1 0 1 1 1",
                  cmos_vsync, cmos_href, frame_start_o, busy_o, frame_cnt_o);
      end
   endtask

   task automatic test_bars();
      logic [7:0] exp_l0 [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                  8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};
      run_frame(0, 16'h0, 1, 50, 1, 16'h0, -1);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (line0[i] !== exp_l0[i]) begin
            failures++;
            $display("FAIL bars_beat%0d got %h want %h", i, line0[i], exp_l0[i]);
         end
      end
      for (int i = L - 4; i < L; i++) begin
         checks++;
         if (line0[i] !== 8'h00) begin
            failures++;
            $display("FAIL bars_tail%0d got %h want 00", i, line0[i]);
         end
      end
      checks++;
      if (href_cnt != V * L) begin
         failures++;
         $display("FAIL href_count got %0d want %0d", href_cnt, V * L);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(1, 16'h0, 2, 70, 2, 16'h0, -1);
      checks++;
      if (href_cnt != V * L) begin
         failures++;
         $display("FAIL href_count2 got %0d want %0d", href_cnt, V * L);
      end
   endtask

   task automatic test_mode_change();
      run_frame(2, 16'h0, 3, 10, 0, 16'h0, -1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (line0[i] !== ((i < 8) ? 8'hFF : 8'h00)) begin
            failures++;
            $display("FAIL checker_beat%0d got %h want %h", i, line0[i],
                     (i < 8) ? 8'hFF : 8'h00);
         end
      end
      run_frame(0, 16'h0, 4, 20, 3, 16'h0, -1);
   endtask

   task automatic test_noise();
      logic [15:0] fl;
      fl = 16'($urandom);
      for (int f = 0; f < 2; f++) begin
         run_frame(3, 16'h0, 5 + f, 30, (f == 0) ? 3 : 4, fl, -1);
         checks++;
         if ({line0[0], line0[1]} !== 16'hACE1) begin
            failures++;
            $display("FAIL noise_first%0d got %h%h want ACE1", f, line0[0], line0[1]);
         end
      end
      run_frame(4, fl, 7, -1, 0, 16'h0, VS + VB + 2 * LT + 10);
      check_idle("enable_drop", 20, 7);
   endtask

   task automatic test_random();
      int m, nm, cp;
      logic [15:0] fl, nfl;
      m = $urandom_range(0, 7);
      fl = 16'($urandom);
      mode_i = 3'(m);
      fill_i = fl;
      enable_i = 1'b1;
      tick();
      for (int f = 0; f < 3; f++) begin
         nm = $urandom_range(0, 7);
         nfl = 16'($urandom);
         cp = $urandom_range(1, FRAME - 2);
         run_frame(m, fl, 8 + f, cp, nm, nfl, (f == 2) ? cp : -1);
         m = nm;
         fl = nfl;
      end
      check_idle("random_idle", 5, 10 % (1 << FW));
   endtask

   task automatic test_mid_reset();
      mode_i = 3'd3;
      enable_i = 1'b1;
      tick();
      repeat (VS + VB + LT + 7) tick();
      checks++;
      if (cmos_href !== 1'b1 || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset got hr=%b bz=%b want 1 1", cmos_href, busy_o);
      end
      rst = 1'b1;
      enable_i = 1'b0;
      tick();
      check_idle("mid_reset", 2, 0);
      rst = 1'b0;
      check_idle("post_reset", 5, 0);
   endtask

   initial begin
      logic [15:0] s;
      logic fb;
      int taps [4] = '{16, 14, 13, 11};
      s = 16'hACE1;
      for (int i = 0; i < H * V; i++) begin
         noise[i] = s;
         fb = 1'b0;
         for (int t = 0; t < 4; t++) fb ^= s[16 - taps[t]];
         s = {fb, s[15:1]};
      end
      test_reset();
      test_bars();
      test_back_to_back();
      test_mode_change();
      test_noise();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
